// File: rtl/motor_command_scheduler.sv
// motor_command_scheduler: arbitrates stop/drive/refresh requests and
// streams {"T":1,"L":x.x,"R":x.x}\n over a valid/ready byte link.
module motor_command_scheduler #(
  parameter int unsigned REFRESH_CLKS = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stop_req,
  input  logic       drive_req,
  input  logic [4:0] drive_left,
  input  logic [4:0] drive_right,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       msg_done
);

  typedef enum logic [1:0] {
    S_IDLE, S_SNAP, S_SEND, S_DONE
  } state_t;

  localparam logic [31:0] RC = 32'(REFRESH_CLKS);

  state_t r_state, w_next;
  logic r_stop_pend, r_drive_pend;
  logic signed [4:0] r_pend_l, r_pend_r;
  logic signed [4:0] r_last_l, r_last_r;
  logic signed [4:0] r_msg_l, r_msg_r;
  logic [4:0] r_idx, r_len;
  logic [31:0] r_idle_cnt;

  logic w_refresh, w_take_stop, w_take_drive, w_take_refr;
  logic w_accept, w_last, w_neg_l, w_neg_r;
  logic [4:0] w_lenl, w_lenr, w_r0, w_sr, w_end, w_off;
  logic [7:0] w_byte;

  function automatic logic signed [4:0] clamp(input logic signed [4:0] v);
    if (v < -5'sd10) return -5'sd10;
    if (v > 5'sd10) return 5'sd10;
    return v;
  endfunction

  function automatic logic [7:0] spd_char(input logic signed [4:0] v,
                                          input logic [2:0] k);
    logic signed [4:0] a;
    logic [7:0] ip, fp;
    a = v[4] ? -v : v;
    ip = (a[3:0] == 4'd10) ? 8'h31 : 8'h30;
    fp = (a[3:0] == 4'd10) ? 8'h30 : 8'h30 + {4'd0, a[3:0]};
    if (v[4]) begin
      case (k)
        3'd0: return 8'h2D;
        3'd1: return ip;
        3'd2: return 8'h2E;
        default: return fp;
      endcase
    end
    case (k)
      3'd0: return ip;
      3'd1: return 8'h2E;
      default: return fp;
    endcase
  endfunction

  function automatic logic [7:0] pre_char(input logic [3:0] k);
    case (k)
      4'd0: return 8'h7B;
      4'd2: return 8'h54;
      4'd4: return 8'h3A;
      4'd5: return 8'h31;
      4'd6: return 8'h2C;
      4'd8: return 8'h4C;
      4'd10: return 8'h3A;
      default: return 8'h22;
    endcase
  endfunction

  function automatic logic [7:0] mid_char(input logic [2:0] k);
    case (k)
      3'd0: return 8'h2C;
      3'd2: return 8'h52;
      3'd4: return 8'h3A;
      default: return 8'h22;
    endcase
  endfunction

  assign w_refresh = (RC != 32'd0) && (r_idle_cnt == RC);
  assign w_take_stop = (r_state == S_IDLE) && r_stop_pend;
  assign w_take_drive = (r_state == S_IDLE) && !r_stop_pend
                        && r_drive_pend;
  assign w_take_refr = (r_state == S_IDLE) && !r_stop_pend
                       && !r_drive_pend && w_refresh;
  assign w_accept = (r_state == S_SEND) && tx_ready;
  assign w_last = (r_idx == r_len - 5'd1);
  assign w_neg_l = r_msg_l[4];
  assign w_neg_r = r_msg_r[4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_stop_pend  <= 1'b0;
      r_drive_pend <= 1'b0;
      r_pend_l     <= '0;
      r_pend_r     <= '0;
      r_last_l     <= '0;
      r_last_r     <= '0;
      r_msg_l      <= '0;
      r_msg_r      <= '0;
      r_idx        <= '0;
      r_len        <= '0;
      r_idle_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_take_stop) begin
        r_stop_pend  <= 1'b0;
        r_drive_pend <= 1'b0;
      end else if (w_take_drive) begin
        r_drive_pend <= 1'b0;
      end
      // new requests win over the clear of the flag being taken
      if (stop_req) begin
        r_stop_pend <= 1'b1;
      end else if (drive_req) begin
        r_drive_pend <= 1'b1;
        r_pend_l     <= $signed(drive_left);
        r_pend_r     <= $signed(drive_right);
      end
      if (w_take_stop) begin
        r_msg_l <= '0;
        r_msg_r <= '0;
      end else if (w_take_drive) begin
        r_msg_l <= clamp(r_pend_l);
        r_msg_r <= clamp(r_pend_r);
      end else if (w_take_refr) begin
        r_msg_l <= r_last_l;
        r_msg_r <= r_last_r;
      end
      if (r_state == S_SNAP) begin
        r_last_l <= r_msg_l;
        r_last_r <= r_msg_r;
        r_idx    <= '0;
        r_len    <= 5'd24 + {4'd0, w_neg_l} + {4'd0, w_neg_r};
      end else if (w_accept) begin
        r_idx <= r_idx + 5'd1;
      end
      if (r_state == S_DONE) begin
        r_idle_cnt <= '0;
      end else if (r_state == S_IDLE && !r_stop_pend && !r_drive_pend
                   && r_idle_cnt != RC) begin
        r_idle_cnt <= r_idle_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_take_stop || w_take_drive || w_take_refr) w_next = S_SNAP;
      S_SNAP: w_next = S_SEND;
      S_SEND: if (w_accept && w_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_lenl = w_neg_l ? 5'd4 : 5'd3;
    w_lenr = w_neg_r ? 5'd4 : 5'd3;
    w_r0   = 5'd11 + w_lenl;
    w_sr   = w_r0 + 5'd5;
    w_end  = w_sr + w_lenr;
    w_off  = '0;
    w_byte = 8'h0A;
    if (r_idx < 5'd11) begin
      w_byte = pre_char(r_idx[3:0]);
    end else if (r_idx < w_r0) begin
      w_off  = r_idx - 5'd11;
      w_byte = spd_char(r_msg_l, w_off[2:0]);
    end else if (r_idx < w_sr) begin
      w_off  = r_idx - w_r0;
      w_byte = mid_char(w_off[2:0]);
    end else if (r_idx < w_end) begin
      w_off  = r_idx - w_sr;
      w_byte = spd_char(r_msg_r, w_off[2:0]);
    end else if (r_idx == w_end) begin
      w_byte = 8'h7D;
    end
  end

  assign tx_valid = (r_state == S_SEND);
  assign tx_data  = tx_valid ? w_byte : 8'h00;
  assign busy     = (r_state != S_IDLE);
  assign msg_done = (r_state == S_DONE);

endmodule

// File: tb/tb_motor_command_scheduler.sv
// Scoreboard bench: expected message bytes are queued at request time
// and compared against every presented byte; a second DUT covers refresh.
module tb_motor_command_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, stop_req, drive_req, tx_ready;
  logic [4:0] drive_left, drive_right;
  logic [7:0] tx_data;
  logic tx_valid, busy, msg_done;

  logic d1_rst_n, d1_stop, d1_drive, d1_ready;
  logic [4:0] d1_l, d1_r;
  logic [7:0] d1_data;
  logic d1_valid, d1_busy, d1_done;

  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] q0[$];
  int n_done = 0;
  int exp_done = 0;
  int n_acc = 0;
  logic last_acc = 1'b0;
  int cyc = 0;

  string exp1;
  int i1 = 0;
  int n1_done = 0;
  int done1_cyc = 0;
  logic prev1_valid = 1'b0;

  motor_command_scheduler #(.REFRESH_CLKS(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .stop_req(stop_req), .drive_req(drive_req),
    .drive_left(drive_left), .drive_right(drive_right),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .msg_done(msg_done)
  );

  motor_command_scheduler #(.REFRESH_CLKS(20)) dut_rf (
    .clk(clk), .rst_n(d1_rst_n),
    .stop_req(d1_stop), .drive_req(d1_drive),
    .drive_left(d1_l), .drive_right(d1_r),
    .tx_data(d1_data), .tx_valid(d1_valid), .tx_ready(d1_ready),
    .busy(d1_busy), .msg_done(d1_done)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic string fmt(input int v);
    int c, m;
    string sg;
    c = (v < -10) ? -10 : ((v > 10) ? 10 : v);
    m = (c < 0) ? -c : c;
    if (c < 0) sg = "-";
    else sg = "";
    return $sformatf("%s%0d.%0d", sg, m / 10, m % 10);
  endfunction

  function automatic string msg_str(input int l, input int r);
    return {"{\"T\":1,\"L\":", fmt(l), ",\"R\":", fmt(r), "}\n"};
  endfunction

  task automatic push_msg(input int l, input int r);
    string s;
    s = msg_str(l, r);
    for (int i = 0; i < s.len(); i++) q0.push_back(s[i]);
    exp_done++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic d,
                       input int l, input int r);
    stop_req = s;
    drive_req = d;
    drive_left = 5'(l);
    drive_right = 5'(r);
    step();
    stop_req = 1'b0;
    drive_req = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q0.size() != 0 || busy) && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_time", n < budget, 1);
    repeat (10) step();
    chk("done_cnt", n_done, exp_done);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (msg_done) begin
      n_done++;
      chk("done_after_last", last_acc, 1);
    end
    last_acc = 1'b0;
    if (tx_valid) begin
      if (q0.size() == 0) begin
        chk("unexpected_byte", 1, 0);
      end else begin
        chk("byte", tx_data, q0[0]);
        if (tx_ready) begin
          last_acc = (q0[0] == 8'h0A);
          void'(q0.pop_front());
          n_acc++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (d1_rst_n) begin
      if (d1_done) begin
        n1_done++;
        done1_cyc = cyc;
      end
      if (d1_valid && !prev1_valid && n1_done > 0)
        chk("rf_gap", (cyc - done1_cyc) inside {[22:24]}, 1);
      if (d1_valid) begin
        chk("rf_byte", d1_data, exp1[i1]);
        i1 = (i1 + 1) % exp1.len();
      end
      prev1_valid = d1_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp1 = msg_str(1, -1);
    rst_n = 1'b0;
    stop_req = 1'b0;
    drive_req = 1'b0;
    drive_left = '0;
    drive_right = '0;
    tx_ready = 1'b1;
    d1_rst_n = 1'b0;
    d1_stop = 1'b0;
    d1_drive = 1'b0;
    d1_l = '0;
    d1_r = '0;
    d1_ready = 1'b1;
    repeat (3) step();
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", msg_done, 0);
    rst_n = 1'b1;
    step();

    pulse(0, 1, 5, 5);
    push_msg(5, 5);
    chk("lat_idle_valid", tx_valid, 0);
    step();
    chk("lat_snap_valid", tx_valid, 0);
    chk("lat_snap_busy", busy, 1);
    step();
    chk("lat_send_valid", tx_valid, 1);
    drain(100);
    repeat (100) step();
    chk("no_refresh", n_done, exp_done);

    pulse(0, 1, -7, 15);
    push_msg(-7, 15);
    drain(100);
    pulse(0, 1, -16, 0);
    push_msg(-16, 0);
    drain(100);

    pulse(1, 1, 3, 3);
    push_msg(0, 0);
    drain(100);

    pulse(0, 1, 6, -3);
    push_msg(6, -3);
    repeat (5) step();
    pulse(1, 0, 0, 0);
    push_msg(0, 0);
    pulse(0, 1, 2, 0);
    pulse(0, 1, 4, 0);
    drain(200);
    repeat (60) step();
    chk("no_third_msg", n_done, exp_done);

    n_acc = 0;
    pulse(0, 1, -7, 15);
    push_msg(-7, 15);
    begin
      int n;
      n = 0;
      while (n_acc < 10 && n < 500) begin
        tx_ready = 1'($urandom_range(0, 1));
        step();
        n++;
      end
      chk("throttle_in_time", n < 500, 1);
    end
    tx_ready = 1'b0;
    rst_n = 1'b0;
    step();
    chk("abort_valid", tx_valid, 0);
    chk("abort_data", tx_data, 0);
    chk("abort_busy", busy, 0);
    q0.delete();
    exp_done--;
    rst_n = 1'b1;
    tx_ready = 1'b1;
    repeat (60) step();
    chk("after_abort_done", n_done, exp_done);

    d1_rst_n = 1'b1;
    d1_drive = 1'b1;
    d1_l = 5'(1);
    d1_r = 5'(-1);
    step();
    d1_drive = 1'b0;
    repeat (200) step();
    chk("rf_count", n1_done inside {[3:4]}, 1);

    chk("final_queue", q0.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
